// File: rtl/riscv_csr_regs.sv
`default_nettype none
// ============================================================================
// Module   : riscv_csr_regs
// Purpose  : Machine-mode CSR register file. Sits behind the CSR access
//            decoder and performs read-modify-write on the architected
//            machine CSRs, owns the mcycle/minstret counters, trap entry and
//            mret state updates, and interrupt-pending generation. Read data
//            is returned one cycle after the access.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            csr_access[2:0]       - 0 none, 1 write, 2 read, 3 read/write,
//                                    6 read/set, 7 read/clear
//            csr_select[11:0]      - decoded CSR code
//            illegal_access        - decoder illegal flag (blocks all writes)
//            write_data[31:0]      - write/set/clear operand
//            time_value[63:0]      - external time counter (read-only view)
//            instr_retired         - increments minstret
//            irq_external/timer/software - level interrupt inputs
//            trap_valid, trap_interrupt, trap_cause, trap_pc, trap_value
//                                  - trap entry request and its payload
//            mret                  - return from machine trap
//            read_valid/read_error/read_data - registered access response
//            mtvec_out, mepc_out   - current register values
//            irq_pending           - MIE & |(mie & mip)
// Revision : 1.0 - initial release
// ============================================================================
module riscv_csr_regs #(
    parameter logic [31:0] MISA        = 32'h4000_0100,
    parameter logic [31:0] MVENDORID   = 32'h0,
    parameter logic [31:0] MARCHID     = 32'h0,
    parameter logic [31:0] MIMPID      = 32'h0,
    parameter logic [31:0] MHARTID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  csr_access,
    input  logic [11:0] csr_select,
    input  logic        illegal_access,
    input  logic [31:0] write_data,
    input  logic [63:0] time_value,
    input  logic        instr_retired,
    input  logic        irq_external,
    input  logic        irq_timer,
    input  logic        irq_software,
    input  logic        trap_valid,
    input  logic        trap_interrupt,
    input  logic [4:0]  trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_value,
    input  logic        mret,
    output logic        read_valid,
    output logic        read_error,
    output logic [31:0] read_data,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        irq_pending
);

    localparam logic [11:0] c_SEL_TIME_LO     = 12'h010;
    localparam logic [11:0] c_SEL_TIME_HI     = 12'h011;
    localparam logic [11:0] c_SEL_MCYCLE_LO   = 12'h012;
    localparam logic [11:0] c_SEL_MCYCLE_HI   = 12'h013;
    localparam logic [11:0] c_SEL_MINSTRET_LO = 12'h014;
    localparam logic [11:0] c_SEL_MINSTRET_HI = 12'h015;
    localparam logic [11:0] c_SEL_MISA        = 12'h020;
    localparam logic [11:0] c_SEL_MVENDORID   = 12'h021;
    localparam logic [11:0] c_SEL_MARCHID     = 12'h022;
    localparam logic [11:0] c_SEL_MIMPID      = 12'h023;
    localparam logic [11:0] c_SEL_MHARTID     = 12'h024;
    localparam logic [11:0] c_SEL_MSTATUS     = 12'h080;
    localparam logic [11:0] c_SEL_MSCRATCH    = 12'h081;
    localparam logic [11:0] c_SEL_MIE         = 12'h082;
    localparam logic [11:0] c_SEL_MIP         = 12'h083;
    localparam logic [11:0] c_SEL_MTVEC       = 12'h084;
    localparam logic [11:0] c_SEL_MTVAL       = 12'h085;
    localparam logic [11:0] c_SEL_MEPC        = 12'h086;
    localparam logic [11:0] c_SEL_MCAUSE      = 12'h087;

    // Interrupt enable/pending bits: MEIE/MEIP[11], MTIE/MTIP[7], MSIE/MSIP[3]
    localparam logic [31:0] c_IRQ_MASK   = 32'h0000_0888;
    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mscratch;
    logic [31:0] r_mie;
    logic [31:0] r_mip;
    logic [31:0] r_mtvec;
    logic [31:0] r_mtval;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    logic [31:0] w_mstatus;
    logic [31:0] w_old;
    logic [31:0] w_wval;
    logic        w_wr;
    logic        w_we_mcycle_lo;
    logic        w_we_mcycle_hi;
    logic        w_we_minstret_lo;
    logic        w_we_minstret_hi;
    logic        w_we_mstatus;
    logic        w_we_mscratch;
    logic        w_we_mie;
    logic        w_we_mtvec;
    logic        w_we_mtval;
    logic        w_we_mepc;
    logic        w_we_mcause;
    logic        w_mcycle_carry;
    logic        w_minstret_carry;

    // MPP is hard-wired to machine mode
    assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

    // Pre-write value of the selected CSR; also the value returned by a read
    always_comb begin
        w_old = 32'h0;
        case (csr_select)
            c_SEL_TIME_LO:     w_old = time_value[31:0];
            c_SEL_TIME_HI:     w_old = time_value[63:32];
            c_SEL_MCYCLE_LO:   w_old = r_mcycle[31:0];
            c_SEL_MCYCLE_HI:   w_old = r_mcycle[63:32];
            c_SEL_MINSTRET_LO: w_old = r_minstret[31:0];
            c_SEL_MINSTRET_HI: w_old = r_minstret[63:32];
            c_SEL_MISA:        w_old = MISA;
            c_SEL_MVENDORID:   w_old = MVENDORID;
            c_SEL_MARCHID:     w_old = MARCHID;
            c_SEL_MIMPID:      w_old = MIMPID;
            c_SEL_MHARTID:     w_old = MHARTID;
            c_SEL_MSTATUS:     w_old = w_mstatus;
            c_SEL_MSCRATCH:    w_old = r_mscratch;
            c_SEL_MIE:         w_old = r_mie;
            c_SEL_MIP:         w_old = r_mip;
            c_SEL_MTVEC:       w_old = r_mtvec;
            c_SEL_MTVAL:       w_old = r_mtval;
            c_SEL_MEPC:        w_old = r_mepc;
            c_SEL_MCAUSE:      w_old = r_mcause;
            default:           w_old = 32'h0;
        endcase
    end

    always_comb begin
        w_wval = write_data;
        case (csr_access)
            3'd6:    w_wval = w_old | write_data;
            3'd7:    w_wval = w_old & ~write_data;
            default: w_wval = write_data;
        endcase
    end

    assign w_wr = !illegal_access &&
                  ((csr_access == 3'd1) || (csr_access == 3'd3) ||
                   (csr_access == 3'd6) || (csr_access == 3'd7));

    assign w_we_mcycle_lo   = w_wr && (csr_select == c_SEL_MCYCLE_LO);
    assign w_we_mcycle_hi   = w_wr && (csr_select == c_SEL_MCYCLE_HI);
    assign w_we_minstret_lo = w_wr && (csr_select == c_SEL_MINSTRET_LO);
    assign w_we_minstret_hi = w_wr && (csr_select == c_SEL_MINSTRET_HI);
    assign w_we_mstatus     = w_wr && (csr_select == c_SEL_MSTATUS);
    assign w_we_mscratch    = w_wr && (csr_select == c_SEL_MSCRATCH);
    assign w_we_mie         = w_wr && (csr_select == c_SEL_MIE);
    assign w_we_mtvec       = w_wr && (csr_select == c_SEL_MTVEC);
    assign w_we_mtval       = w_wr && (csr_select == c_SEL_MTVAL);
    assign w_we_mepc        = w_wr && (csr_select == c_SEL_MEPC);
    assign w_we_mcause      = w_wr && (csr_select == c_SEL_MCAUSE);

    // A written lo half suppresses the carry into hi for that cycle
    assign w_mcycle_carry   = (r_mcycle[31:0] == 32'hFFFF_FFFF) && !w_we_mcycle_lo;
    assign w_minstret_carry = instr_retired && (r_minstret[31:0] == 32'hFFFF_FFFF) &&
                              !w_we_minstret_lo;

    // Counters: CSR writes beat the increment on the half being written
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcycle   <= 64'h0;
            r_minstret <= 64'h0;
        end else begin
            r_mcycle[31:0]  <= w_we_mcycle_lo ? w_wval : r_mcycle[31:0] + 32'd1;
            r_mcycle[63:32] <= w_we_mcycle_hi ? w_wval :
                               r_mcycle[63:32] + {31'b0, w_mcycle_carry};
            r_minstret[31:0]  <= w_we_minstret_lo ? w_wval :
                                 r_minstret[31:0] + {31'b0, instr_retired};
            r_minstret[63:32] <= w_we_minstret_hi ? w_wval :
                                 r_minstret[63:32] + {31'b0, w_minstret_carry};
        end
    end

    // Trap-owned state: trap > mret > CSR write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mepc         <= 32'h0;
            r_mcause       <= 32'h0;
            r_mtval        <= 32'h0;
        end else begin
            if (trap_valid) begin
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (mret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_we_mstatus) begin
                r_mstatus_mie  <= w_wval[3];
                r_mstatus_mpie <= w_wval[7];
            end

            if (trap_valid) begin
                r_mepc   <= trap_pc & c_ALIGN_MASK;
                r_mcause <= {trap_interrupt, 26'b0, trap_cause};
                r_mtval  <= trap_value;
            end else begin
                if (w_we_mepc)   r_mepc   <= w_wval & c_ALIGN_MASK;
                if (w_we_mcause) r_mcause <= w_wval;
                if (w_we_mtval)  r_mtval  <= w_wval;
            end
        end
    end

    // Software-only registers and the sampled interrupt lines
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mscratch <= 32'h0;
            r_mie      <= 32'h0;
            r_mtvec    <= MTVEC_RESET & c_ALIGN_MASK;
            r_mip      <= 32'h0;
        end else begin
            if (w_we_mscratch) r_mscratch <= w_wval;
            if (w_we_mie)      r_mie      <= w_wval & c_IRQ_MASK;
            if (w_we_mtvec)    r_mtvec    <= w_wval & c_ALIGN_MASK;
            r_mip <= {20'b0, irq_external, 3'b0, irq_timer, 3'b0, irq_software, 3'b0};
        end
    end

    // Access response, one cycle after the access
    always_ff @(posedge clk) begin
        if (reset) begin
            read_valid <= 1'b0;
            read_error <= 1'b0;
            read_data  <= 32'h0;
        end else begin
            read_valid <= (csr_access != 3'd0);
            read_error <= (csr_access != 3'd0) && illegal_access;
            read_data  <= ((csr_access != 3'd0) && !illegal_access) ? w_old : 32'h0;
        end
    end

    assign mtvec_out   = r_mtvec;
    assign mepc_out    = r_mepc;
    assign irq_pending = r_mstatus_mie && (|(r_mie & r_mip));

endmodule
`default_nettype wire

// File: tb/tb_riscv_csr_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_csr_regs
// Purpose  : Directed self-checking bench for riscv_csr_regs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_csr_regs;

    logic        clk;
    logic        reset;
    logic [2:0]  csr_access;
    logic [11:0] csr_select;
    logic        illegal_access;
    logic [31:0] write_data;
    logic [63:0] time_value;
    logic        instr_retired;
    logic        irq_external;
    logic        irq_timer;
    logic        irq_software;
    logic        trap_valid;
    logic        trap_interrupt;
    logic [4:0]  trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_value;
    logic        mret;
    logic        read_valid;
    logic        read_error;
    logic [31:0] read_data;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        irq_pending;

    int checks = 0;
    int errors = 0;

    riscv_csr_regs dut (
        .clk            (clk),
        .reset          (reset),
        .csr_access     (csr_access),
        .csr_select     (csr_select),
        .illegal_access (illegal_access),
        .write_data     (write_data),
        .time_value     (time_value),
        .instr_retired  (instr_retired),
        .irq_external   (irq_external),
        .irq_timer      (irq_timer),
        .irq_software   (irq_software),
        .trap_valid     (trap_valid),
        .trap_interrupt (trap_interrupt),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .trap_value     (trap_value),
        .mret           (mret),
        .read_valid     (read_valid),
        .read_error     (read_error),
        .read_data      (read_data),
        .mtvec_out      (mtvec_out),
        .mepc_out       (mepc_out),
        .irq_pending    (irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one access for one clock edge, then return to idle; outputs are
    // stable for checking 1 time unit after the edge.
    task automatic cyc(input logic [2:0] acc, input logic [11:0] sel,
                       input logic [31:0] wd, input logic ill);
        csr_access     = acc;
        csr_select     = sel;
        write_data     = wd;
        illegal_access = ill;
        @(posedge clk);
        #1;
        csr_access     = 3'd0;
        csr_select     = 12'h0;
        write_data     = 32'h0;
        illegal_access = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) cyc(3'd0, 12'h0, 32'h0, 1'b0);
        // access during the final reset cycle must not produce read_valid
        cyc(3'd2, 12'h020, 32'h0, 1'b0);
        reset = 1'b0;
        checks++;
        if (read_valid !== 1'b0) begin
            errors++; $display("FAIL reset_read_valid got %b exp 0", read_valid);
        end
        checks++;
        if (read_data !== 32'h0) begin
            errors++; $display("FAIL reset_read_data got %h exp 0", read_data);
        end
        checks++;
        if (mtvec_out !== 32'h0 || mepc_out !== 32'h0 || irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got mtvec %h mepc %h irq %b exp 0 0 0",
                     mtvec_out, mepc_out, irq_pending);
        end
        cyc(3'd0, 12'h0, 32'h0, 1'b0);
        checks++;
        if (read_valid !== 1'b0) begin
            errors++; $display("FAIL reset_no_late_valid got %b exp 0", read_valid);
        end
    endtask

    task automatic test_mcycle();
        // one idle edge already elapsed in test_reset; four more makes five
        repeat (4) cyc(3'd0, 12'h0, 32'h0, 1'b0);
        cyc(3'd2, 12'h012, 32'h0, 1'b0);
        checks++;
        if (read_valid !== 1'b1 || read_error !== 1'b0 || read_data !== 32'd5) begin
            errors++;
            $display("FAIL mcycle_lo got v%b e%b %h exp v1 e0 5", read_valid, read_error, read_data);
        end
        cyc(3'd2, 12'h013, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h0) begin
            errors++; $display("FAIL mcycle_hi got %h exp 0", read_data);
        end
        cyc(3'd1, 12'h012, 32'hFFFF_FFFE, 1'b0);
        repeat (2) cyc(3'd0, 12'h0, 32'h0, 1'b0);
        cyc(3'd2, 12'h013, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h1) begin
            errors++; $display("FAIL mcycle_carry got %h exp 1", read_data);
        end
        cyc(3'd2, 12'h012, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h1) begin
            errors++; $display("FAIL mcycle_wrapped_lo got %h exp 1", read_data);
        end
        // a write to the hi half beats the carry out of lo
        cyc(3'd1, 12'h012, 32'hFFFF_FFFF, 1'b0);
        cyc(3'd1, 12'h013, 32'h0000_0007, 1'b0);
        cyc(3'd2, 12'h013, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h7) begin
            errors++; $display("FAIL mcycle_hi_write got %h exp 7", read_data);
        end
    endtask

    task automatic test_minstret();
        cyc(3'd2, 12'h014, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h0) begin
            errors++; $display("FAIL minstret_idle got %h exp 0", read_data);
        end
        instr_retired = 1'b1;
        cyc(3'd1, 12'h014, 32'hFFFF_FFFF, 1'b0);
        cyc(3'd0, 12'h0, 32'h0, 1'b0);
        instr_retired = 1'b0;
        cyc(3'd2, 12'h015, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h1) begin
            errors++; $display("FAIL minstret_carry got %h exp 1", read_data);
        end
        cyc(3'd2, 12'h014, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h0) begin
            errors++; $display("FAIL minstret_wrap got %h exp 0", read_data);
        end
        // written lo (old value all ones) must neither increment nor carry
        cyc(3'd1, 12'h014, 32'hFFFF_FFFF, 1'b0);
        instr_retired = 1'b1;
        cyc(3'd1, 12'h014, 32'h0000_0100, 1'b0);
        instr_retired = 1'b0;
        cyc(3'd2, 12'h014, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h100) begin
            errors++; $display("FAIL minstret_write_beats_inc got %h exp 100", read_data);
        end
        cyc(3'd2, 12'h015, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h1) begin
            errors++; $display("FAIL minstret_no_carry_on_write got %h exp 1", read_data);
        end
    endtask

    task automatic test_rmw_and_ids();
        cyc(3'd1, 12'h081, 32'hA5A5_0000, 1'b0);
        cyc(3'd6, 12'h081, 32'h0000_00FF, 1'b0);
        checks++;
        if (read_data !== 32'hA5A5_0000) begin
            errors++; $display("FAIL set_returns_old got %h exp a5a50000", read_data);
        end
        cyc(3'd2, 12'h081, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'hA5A5_00FF) begin
            errors++; $display("FAIL mscratch_set got %h exp a5a500ff", read_data);
        end
        cyc(3'd7, 12'h081, 32'hA500_0000, 1'b0);
        cyc(3'd3, 12'h081, 32'h0000_1234, 1'b0);
        checks++;
        if (read_data !== 32'h00A5_00FF) begin
            errors++; $display("FAIL mscratch_clear got %h exp 00a500ff", read_data);
        end
        cyc(3'd2, 12'h081, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h0000_1234) begin
            errors++; $display("FAIL mscratch_rw got %h exp 1234", read_data);
        end
        // read-only access type must not write
        cyc(3'd2, 12'h081, 32'hFFFF_FFFF, 1'b0);
        cyc(3'd2, 12'h081, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h0000_1234) begin
            errors++; $display("FAIL read_no_write got %h exp 1234", read_data);
        end
        cyc(3'd1, 12'h084, 32'h0000_1237, 1'b0);
        checks++;
        if (mtvec_out !== 32'h0000_1234) begin
            errors++; $display("FAIL mtvec_align got %h exp 1234", mtvec_out);
        end
        cyc(3'd2, 12'h020, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h4000_0100) begin
            errors++; $display("FAIL misa got %h exp 40000100", read_data);
        end
        cyc(3'd1, 12'h099, 32'hFFFF_FFFF, 1'b0);
        cyc(3'd2, 12'h099, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h0 || read_valid !== 1'b1) begin
            errors++; $display("FAIL unmapped got v%b %h exp v1 0", read_valid, read_data);
        end
        cyc(3'd2, 12'h010, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h3333_4444) begin
            errors++; $display("FAIL time_lo got %h exp 33334444", read_data);
        end
        cyc(3'd2, 12'h011, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h1111_2222) begin
            errors++; $display("FAIL time_hi got %h exp 11112222", read_data);
        end
        cyc(3'd0, 12'h0, 32'h0, 1'b0);
        checks++;
        if (read_valid !== 1'b0) begin
            errors++; $display("FAIL idle_valid got %b exp 0", read_valid);
        end
    endtask

    task automatic test_trap_mret();
        cyc(3'd1, 12'h080, 32'h0000_0008, 1'b0);
        cyc(3'd1, 12'h082, 32'h0000_0800, 1'b0);
        irq_external = 1'b1;
        #1;
        checks++;
        if (irq_pending !== 1'b0) begin
            errors++; $display("FAIL irq_latency got %b exp 0", irq_pending);
        end
        cyc(3'd0, 12'h0, 32'h0, 1'b0);
        checks++;
        if (irq_pending !== 1'b1) begin
            errors++; $display("FAIL irq_pending got %b exp 1", irq_pending);
        end
        trap_valid = 1'b1; trap_interrupt = 1'b1; trap_cause = 5'd11;
        trap_pc = 32'h0000_1003; trap_value = 32'h0000_DEAD;
        cyc(3'd0, 12'h0, 32'h0, 1'b0);
        trap_valid = 1'b0; trap_interrupt = 1'b0;
        checks++;
        if (mepc_out !== 32'h0000_1000 || irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL trap_mepc got %h irq %b exp 1000 0", mepc_out, irq_pending);
        end
        cyc(3'd2, 12'h087, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h8000_000B) begin
            errors++; $display("FAIL trap_mcause got %h exp 8000000b", read_data);
        end
        cyc(3'd2, 12'h080, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h0000_1880) begin
            errors++; $display("FAIL trap_mstatus got %h exp 1880", read_data);
        end
        cyc(3'd2, 12'h085, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h0000_DEAD) begin
            errors++; $display("FAIL trap_mtval got %h exp dead", read_data);
        end
        mret = 1'b1;
        cyc(3'd0, 12'h0, 32'h0, 1'b0);
        mret = 1'b0;
        cyc(3'd2, 12'h080, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h0000_1888 || irq_pending !== 1'b1) begin
            errors++;
            $display("FAIL mret_mstatus got %h irq %b exp 1888 1", read_data, irq_pending);
        end
    endtask

    task automatic test_illegal_and_mip();
        cyc(3'd1, 12'h086, 32'h0000_5554, 1'b1);
        checks++;
        if (read_valid !== 1'b1 || read_error !== 1'b1 || read_data !== 32'h0 ||
            mepc_out !== 32'h0000_1000) begin
            errors++;
            $display("FAIL illegal got v%b e%b %h mepc %h exp v1 e1 0 1000",
                     read_valid, read_error, read_data, mepc_out);
        end
        cyc(3'd1, 12'h083, 32'h0000_FFFF, 1'b0);
        cyc(3'd2, 12'h083, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h0000_0800 || read_error !== 1'b0) begin
            errors++; $display("FAIL mip_readonly got %h e%b exp 800 e0", read_data, read_error);
        end
        irq_external = 1'b0;
        irq_timer    = 1'b1;
        irq_software = 1'b1;
        cyc(3'd0, 12'h0, 32'h0, 1'b0);
        cyc(3'd2, 12'h083, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h0000_0088 || irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL mip_track got %h irq %b exp 88 0", read_data, irq_pending);
        end
    endtask

    task automatic test_back_to_back();
        // trap beats a same-cycle CSR write to mepc
        trap_valid = 1'b1; trap_cause = 5'd2; trap_pc = 32'h0000_0200; trap_value = 32'h0;
        cyc(3'd1, 12'h086, 32'h0000_0040, 1'b0);
        trap_valid = 1'b0;
        checks++;
        if (mepc_out !== 32'h0000_0200) begin
            errors++; $display("FAIL trap_beats_write got %h exp 200", mepc_out);
        end
        // trap does not block a write to an unrelated register
        trap_valid = 1'b1; trap_pc = 32'h0000_0300;
        cyc(3'd1, 12'h081, 32'h0000_BEEF, 1'b0);
        trap_valid = 1'b0;
        cyc(3'd1, 12'h086, 32'h0000_0043, 1'b0);
        cyc(3'd2, 12'h086, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h0000_0040) begin
            errors++; $display("FAIL b2b_mepc got %h exp 40", read_data);
        end
        cyc(3'd2, 12'h081, 32'h0, 1'b0);
        checks++;
        if (read_data !== 32'h0000_BEEF) begin
            errors++; $display("FAIL trap_other_write got %h exp beef", read_data);
        end
    endtask

    initial begin
        reset = 1'b1; csr_access = 3'd0; csr_select = 12'h0; illegal_access = 1'b0;
        write_data = 32'h0; time_value = 64'h1111_2222_3333_4444; instr_retired = 1'b0;
        irq_external = 1'b0; irq_timer = 1'b0; irq_software = 1'b0;
        trap_valid = 1'b0; trap_interrupt = 1'b0; trap_cause = 5'd0;
        trap_pc = 32'h0; trap_value = 32'h0; mret = 1'b0;
        #2;
        test_reset();
        test_mcycle();
        test_minstret();
        test_rmw_and_ids();
        test_trap_mret();
        test_illegal_and_mip();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
`default_nettype wire
